// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: sequencer states, opcodes,
// ALU function codes and instruction field positions.
package proc_pkg;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD_A = 4'd3,
      S_LOAD_B = 4'd4,
      S_STORE  = 4'd5,
      S_ADD    = 4'd6,
      S_SUB    = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   localparam int OP_HI     = 15;
   localparam int OP_LO     = 12;
   localparam int LD_ADDR_HI = 11;
   localparam int LD_ADDR_LO = 4;
   localparam int LD_W_HI   = 3;
   localparam int LD_W_LO   = 0;
   localparam int ST_RA_HI  = 11;
   localparam int ST_RA_LO  = 8;
   localparam int ST_ADDR_HI = 7;
   localparam int ST_ADDR_LO = 0;
   localparam int AR_RA_HI  = 11;
   localparam int AR_RA_LO  = 8;
   localparam int AR_RB_HI  = 7;
   localparam int AR_RB_LO  = 4;
   localparam int AR_W_HI   = 3;
   localparam int AR_W_LO   = 0;

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the 16-bit processor: fetch, decode and multi-cycle
// execute, driving PC, IR, data RAM, register file and ALU select.
//
// state  | meaning
// INIT   | clear PC after reset
// FETCH  | load IR from ROM, bump PC
// DECODE | pick execute state from opcode
// LOAD_A | present RAM address, wait out read latency
// LOAD_B | write RAM data into register file
// STORE  | write register A to RAM
// ADD    | Ra + Rb -> W
// SUB    | Ra - Rb -> W
// HALT   | idle until reset
module control_unit
   import proc_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] IR,
   output logic        PC_clr,
   output logic        PC_up,
   output logic        IR_ld,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s,
   output logic [3:0]  State
);

   state_t state, state_nxt;

   always_ff @(posedge Clk) begin
      if (Reset)
         state <= S_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = 8'h00;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'h0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = 4'h0;
      RF_Rb_addr = 4'h0;
      ALU_s      = ALU_PASS;

      case (state)
         S_INIT: begin
            PC_clr    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            PC_up     = 1'b1;
            IR_ld     = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            case (IR[OP_HI:OP_LO])
               OP_LOAD:  state_nxt = S_LOAD_A;
               OP_STORE: state_nxt = S_STORE;
               OP_ADD:   state_nxt = S_ADD;
               OP_SUB:   state_nxt = S_SUB;
               OP_HALT:  state_nxt = S_HALT;
               default:  state_nxt = S_FETCH;
            endcase
         end
         S_LOAD_A: begin
            D_addr    = IR[LD_ADDR_HI:LD_ADDR_LO];
            RF_s      = 1'b1;
            state_nxt = S_LOAD_B;
         end
         S_LOAD_B: begin
            D_addr    = IR[LD_ADDR_HI:LD_ADDR_LO];
            RF_s      = 1'b1;
            RF_W_addr = IR[LD_W_HI:LD_W_LO];
            RF_W_en   = 1'b1;
            state_nxt = S_FETCH;
         end
         S_STORE: begin
            RF_Ra_addr = IR[ST_RA_HI:ST_RA_LO];
            D_addr     = IR[ST_ADDR_HI:ST_ADDR_LO];
            D_wr       = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_ADD, S_SUB: begin
            RF_Ra_addr = IR[AR_RA_HI:AR_RA_LO];
            RF_Rb_addr = IR[AR_RB_HI:AR_RB_LO];
            RF_W_addr  = IR[AR_W_HI:AR_W_LO];
            RF_W_en    = 1'b1;
            ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            state_nxt  = S_FETCH;
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_INIT;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the stimulus queues hand-computed output
// vectors per cycle, a monitor on the falling edge pops and compares them.
module tb_control_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] IR;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
   logic [2:0]  ALU_s;

   control_unit dut (
      .Clk(Clk), .Reset(Reset), .IR(IR),
      .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .ALU_s(ALU_s), .State(State)
   );

   always #5 Clk = ~Clk;

   logic [32:0] exp_q[$];
   string       name_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, ALU_s}
   function automatic logic [32:0] mk(input logic [3:0] st, input logic clr, input logic up,
                                      input logic ld, input logic [7:0] da, input logic wr,
                                      input logic s, input logic [3:0] wa, input logic we,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [2:0] alu);
      return {st, clr, up, ld, da, wr, s, wa, we, ra, rb, alu};
   endfunction

   always @(negedge Clk) begin
      logic [32:0] act, e;
      string       n;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         n   = name_q.pop_front();
         act = {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
                RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s};
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     n, act, e, act[32:29], e[32:29]);
         end
      end
   end

   task automatic step(input string n, input logic [32:0] v);
      name_q.push_back(n);
      exp_q.push_back(v);
      @(posedge Clk);
      #1;
   endtask

   task automatic c_init(input string n);
      step(n, mk(4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
   endtask
   task automatic c_fetch(input string n);
      step(n, mk(4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
   endtask
   task automatic c_decode(input string n);
      step(n, mk(4'd2, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
   endtask

   initial begin
      Reset = 1'b1;
      IR    = 16'h0000;
      @(posedge Clk);
      #1;
      c_init("reset_hold1");
      c_init("reset_hold2");
      Reset = 1'b0;
      c_init("init_release");
      IR = 16'h21B5;
      c_fetch("fetch_load");
      c_decode("decode_load");
      step("load_a", mk(4'd3, 0, 0, 0, 8'h1B, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      step("load_b", mk(4'd4, 0, 0, 0, 8'h1B, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'b000));
      IR = 16'h1A4C;
      c_fetch("fetch_store");
      c_decode("decode_store");
      step("store", mk(4'd5, 0, 0, 0, 8'h4C, 1, 0, 4'h0, 0, 4'hA, 4'h0, 3'b000));
      IR = 16'h3123;
      c_fetch("fetch_add");
      c_decode("decode_add");
      step("add", mk(4'd6, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'b001));
      IR = 16'h4123;
      c_fetch("fetch_sub");
      c_decode("decode_sub");
      step("sub", mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'b010));
      IR = 16'hF000;
      c_fetch("fetch_unknown");
      c_decode("decode_unknown");
      IR = 16'h0000;
      c_fetch("fetch_noop");
      c_decode("decode_noop");
      IR = 16'h21B5;
      c_fetch("fetch_load2");
      c_decode("decode_load2");
      Reset = 1'b1;
      step("load_a_reset", mk(4'd3, 0, 0, 0, 8'h1B, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      c_init("init_after_abort");
      Reset = 1'b0;
      c_init("init_release2");
      IR = 16'h5000;
      c_fetch("fetch_halt");
      c_decode("decode_halt");
      for (int i = 0; i < 20; i++)
         step("halt", mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      Reset = 1'b1;
      step("halt_reset", mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      c_init("init_from_halt");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(negedge Clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending vectors expected 0", exp_q.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencer for the 16-bit programmable processor. It fetches each instruction from the instruction register and decodes the opcode. It then drives the PC, instruction register, data memory, register file write-back select and the ALU's 3-bit function select (the 8-to-1 result mux) through a multi-cycle FSM. It sits between the instruction path (PC, ROM, IR) and the datapath (data RAM, register file, ALU).

## Interface
- No parameters. Widths are fixed by the ISA: 16-bit instruction, 8-bit data address, 4-bit register address, 3-bit ALU select.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high; forces INIT on the next edge.
- IR  in  16  current instruction from the instruction register.
- PC_clr  out  1  clear program counter.
- PC_up  out  1  increment program counter.
- IR_ld  out  1  load instruction register from ROM.
- D_addr  out  8  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  register-file write source: 1 = data memory, 0 = ALU.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file read port A address.
- RF_Rb_addr  out  4  register-file read port B address.
- ALU_s  out  3  ALU function select: 000 pass A, 001 add, 010 subtract; 011–111 are reserved and are never driven.
- State  out  4  current state encoding, for debug and display.

## Operation
- Opcode is IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. Any other opcode is executed as NOOP.
- Field layout:
  - LOAD: D_addr = IR[11:4], RF_W_addr = IR[3:0].
  - STORE: RF_Ra_addr = IR[11:8], D_addr = IR[7:0].
  - ADD/SUB: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0].
- States:
  - INIT (0): PC_clr = 1. Next state is FETCH.
  - FETCH (1): PC_up = 1, IR_ld = 1. Next state is DECODE.
  - DECODE (2): no strobes. Next state is chosen by opcode: NOOP/unknown → FETCH, LOAD → LOAD_A, STORE → STORE, ADD → ADD, SUB → SUB, HALT → HALT.
  - LOAD_A (3): D_addr driven, RF_s = 1. Covers the one-cycle RAM read latency. Next state is LOAD_B.
  - LOAD_B (4): D_addr driven, RF_s = 1, RF_W_en = 1. Next state is FETCH.
  - STORE (5): RF_Ra_addr and D_addr driven, D_wr = 1. Next state is FETCH.
  - ADD (6): Ra/Rb/W addresses driven, ALU_s = 001, RF_s = 0, RF_W_en = 1. Next state is FETCH.
  - SUB (7): same as ADD but ALU_s = 010. Next state is FETCH.
  - HALT (8): all strobes 0. Stays in HALT until Reset.
- Outputs not listed for a state are 0, including addresses and ALU_s. Address fields are taken from IR only in the states that use them.
- At most one of PC_clr, PC_up, D_wr, RF_W_en is asserted in any state.

## Timing
- State register updates on the rising Clk edge. All outputs are combinational from the state plus IR fields, with no output registers.
- Reset has priority over every transition. After any edge with Reset = 1, State = 0 and all outputs are 0 except PC_clr = 1. The same result holds when Reset is asserted mid-instruction, e.g. during LOAD_A, and no write strobe is issued that cycle.
- Instruction cost (cycles from FETCH to the next FETCH):
  - NOOP: 2.
  - ADD, SUB, STORE: 3.
  - LOAD: 4.
- IR must be stable from DECODE through the end of execute. The IR changes only on an IR_ld edge, so this holds.
- Reset released: INIT → FETCH on the first edge with Reset = 0.

## Structure
- Shared package `proc_pkg`:
  - state enum: 4-bit encoding, values fixed as listed.
  - opcode localparams.
  - ALU_s localparams: ALU_PASS, ALU_ADD, ALU_SUB.
  - field-slice localparams.
- Single flat module with two processes: a sequential state register and a combinational next-state/output block. No sub-module is warranted.

## Test plan
- Reset held 2 cycles, then released → State 0 with PC_clr = 1, then State 1 with PC_up = 1 and IR_ld = 1, then State 2.
- IR = 16'h21B5 (LOAD) → states 3, 4, 1. D_addr = 8'h1B in states 3–4, RF_s = 1, RF_W_en = 1 only in state 4, RF_W_addr = 4'h5.
- IR = 16'h1A4C (STORE) → state 5 with D_wr = 1, RF_Ra_addr = 4'hA, D_addr = 8'h4C, then FETCH.
- IR = 16'h3123 then 16'h4123 → state 6 with ALU_s = 001, then state 7 with ALU_s = 010. Both have Ra = 1, Rb = 2, W = 3, RF_W_en = 1, RF_s = 0.
- IR = 16'h5000 → HALT held for 20 cycles with all strobes 0. IR = 16'hF000 → DECODE → FETCH, behaving as NOOP.
- Reset asserted in LOAD_A → next state INIT. RF_W_en is never asserted for that load.
